// File: rtl/word_index_unit_if.sv
// Handshake and status bundle between the MEM-stage address producer and word_index_unit.
// The slave modport is the unit's side; the master modport is the producer/memory side.
interface word_index_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_size;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-3:0] out_index;
    logic [3:0]        out_byte_en;
    logic              out_misalign;
    logic              err_clr;
    logic              err_sticky;
    logic [7:0]        mis_count;

    modport slave (
        input  in_valid, in_addr, in_size, out_ready, err_clr,
        output in_ready, out_valid, out_index, out_byte_en, out_misalign,
        output err_sticky, mis_count
    );

    modport master (
        output in_valid, in_addr, in_size, out_ready, err_clr,
        input  in_ready, out_valid, out_index, out_byte_en, out_misalign,
        input  err_sticky, mis_count
    );
endinterface

// File: rtl/word_index_unit.sv
// Byte address -> word index + lane enables, 2-entry buffered; WORD_INDEX_ALIGN_TRAP_EN enables alignment trapping.
// Latency: entry accepted at edge N is presented in cycle N+1; no combinational input-to-output path.
// Backpressure: in_ready = !rst && occupancy != 2, independent of out_ready; 1 entry/cycle when out_ready held high.
module word_index_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    word_index_unit_if.slave  bus
);
    localparam int IDX_W = ADDR_W - 2;

    logic [IDX_W-1:0] r_index [2];
    logic [3:0]       r_ben   [2];
    logic             r_mis   [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;
    logic [3:0]       w_base_ben;
    logic [3:0]       w_dec_ben;
    logic             w_dec_mis;

    assign w_in_ready  = !rst && (r_occ != 2'd2);
    assign w_out_valid = (r_occ != 2'd0);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Lane selection always aligns down; size 11 falls through to word lanes.
    always_comb begin
        w_base_ben = 4'b1111;
        case (bus.in_size)
            2'b00:   w_base_ben = 4'b0001 << bus.in_addr[1:0];
            2'b01:   w_base_ben = bus.in_addr[1] ? 4'b1100 : 4'b0011;
            default: w_base_ben = 4'b1111;
        endcase
    end

`ifdef WORD_INDEX_ALIGN_TRAP_EN
    always_comb begin
        w_dec_mis = 1'b1;
        case (bus.in_size)
            2'b00:   w_dec_mis = 1'b0;
            2'b01:   w_dec_mis = bus.in_addr[0];
            2'b10:   w_dec_mis = (bus.in_addr[1:0] != 2'b00);
            default: w_dec_mis = 1'b1;
        endcase
    end

    assign w_dec_ben = w_dec_mis ? 4'b0000 : w_base_ben;
`else
    assign w_dec_mis = 1'b0;
    assign w_dec_ben = w_base_ben;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_index[i] <= '0;
                r_ben[i]   <= '0;
                r_mis[i]   <= 1'b0;
            end
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_index[r_wptr] <= bus.in_addr[ADDR_W-1:2];
                r_ben[r_wptr]   <= w_dec_ben;
                r_mis[r_wptr]   <= w_dec_mis;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Data outputs are forced to zero while empty so the idle bus reads clean.
    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_index    = w_out_valid ? r_index[r_rptr] : '0;
    assign bus.out_byte_en  = w_out_valid ? r_ben[r_rptr]   : 4'b0000;
    assign bus.out_misalign = w_out_valid ? r_mis[r_rptr]   : 1'b0;

`ifdef WORD_INDEX_ALIGN_TRAP_EN
    logic       r_err_sticky;
    logic [7:0] r_mis_count;

    // A misaligned accept in the same cycle as err_clr restarts the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_mis_count  <= 8'd0;
        end else if (w_accept && w_dec_mis) begin
            r_err_sticky <= 1'b1;
            if (bus.err_clr) begin
                r_mis_count <= 8'd1;
            end else if (r_mis_count != 8'hFF) begin
                r_mis_count <= r_mis_count + 8'd1;
            end
        end else if (bus.err_clr) begin
            r_err_sticky <= 1'b0;
            r_mis_count  <= 8'd0;
        end
    end

    assign bus.err_sticky = r_err_sticky;
    assign bus.mis_count  = r_mis_count;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = bus.err_clr;
    assign bus.err_sticky   = 1'b0;
    assign bus.mis_count    = 8'd0;
`endif

endmodule

// File: tb/tb_word_index_unit.sv
// Self-checking bench for word_index_unit; the reference model follows WORD_INDEX_ALIGN_TRAP_EN as the DUT does.
// Model: queue of decoded entries computed from size/offset arithmetic, plus error counters.
module tb_word_index_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    word_index_unit_if #(.ADDR_W(32)) bus ();

    word_index_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] idx;
        logic [3:0]  ben;
        logic        mis;
    } ent_t;

    ent_t       exp_q[$];
    logic       m_sticky = 1'b0;
    logic [7:0] m_count  = 8'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic ent_t model_decode(input logic [31:0] addr, input logic [1:0] size);
        ent_t e;
        int   off;
        int   bytes;
        int   base;
        e.idx = 30'(addr >> 2);
        off   = int'(addr % 4);
        bytes = (size == 2'd3) ? 4 : (1 << size);
        base  = off - (off % bytes);
        e.ben = 4'(((1 << bytes) - 1) << base);
        e.mis = 1'b0;
`ifdef WORD_INDEX_ALIGN_TRAP_EN
        if (size == 2'd3 || (off % bytes) != 0) begin
            e.mis = 1'b1;
            e.ben = 4'b0000;
        end
`endif
        return e;
    endfunction

    // Advance one clock: update the model from the inputs that the edge will see.
    task automatic tick();
        bit   acc;
        bit   pop;
        ent_t e;
        acc = bus.in_valid && !rst && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && bus.out_ready;
        if (rst) begin
            exp_q.delete();
            m_sticky = 1'b0;
            m_count  = 8'd0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                e = model_decode(bus.in_addr, bus.in_size);
                exp_q.push_back(e);
            end
`ifdef WORD_INDEX_ALIGN_TRAP_EN
            if (acc && e.mis) begin
                m_sticky = 1'b1;
                m_count  = bus.err_clr ? 8'd1 : ((m_count == 8'd255) ? 8'd255 : m_count + 8'd1);
            end else if (bus.err_clr) begin
                m_sticky = 1'b0;
                m_count  = 8'd0;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_size = 2'd0;
        bus.out_ready = 1'b0; bus.err_clr = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_index !== 30'd0) begin n_bad++; $display("FAIL reset_out_index: got %h want 0", bus.out_index); end
        n_cmp++; if (bus.out_byte_en !== 4'b0000) begin n_bad++; $display("FAIL reset_byte_en: got %b want 0000", bus.out_byte_en); end
        n_cmp++; if (bus.out_misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", bus.out_misalign); end
        n_cmp++; if ({bus.err_sticky, bus.mis_count} !== 9'd0) begin n_bad++; $display("FAIL reset_err: got %b/%0d want 0/0", bus.err_sticky, bus.mis_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_word_basic();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_addr = 32'h0000_0010; bus.in_size = 2'd2;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL word_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_index !== 30'h0000004) begin n_bad++; $display("FAIL word_index: got %h want 0000004", bus.out_index); end
        n_cmp++; if (bus.out_byte_en !== 4'b1111) begin n_bad++; $display("FAIL word_byte_en: got %b want 1111", bus.out_byte_en); end
        n_cmp++; if (bus.out_misalign !== 1'b0) begin n_bad++; $display("FAIL word_misalign: got %b want 0", bus.out_misalign); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL word_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_byte_back_to_back();
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        bus.out_ready = 1'b1;
        bus.in_size = 2'd0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_addr = base | 32'(i);
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_byte_en !== 4'(1 << i) || bus.out_index !== base[31:2])
            begin
                n_bad++;
                $display("FAIL byte_b2b_%0d: got v=%b en=%b idx=%h want v=1 en=%b idx=%h",
                         i, bus.out_valid, bus.out_byte_en, bus.out_index, 4'(1 << i), base[31:2]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL byte_b2b_end: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] a [3];
        for (int i = 0; i < 3; i++) a[i] = $urandom & 32'hFFFF_FFFC;
        bus.out_ready = 1'b0;
        bus.in_size = 2'd2;
        bus.in_valid = 1'b1;
        bus.in_addr = a[0]; tick();
        bus.in_addr = a[1]; tick();
        bus.in_addr = a[2];
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        tick(); tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready: got %b want 0", bus.in_ready); end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== a[0][31:2] || bus.out_byte_en !== 4'b1111)
        begin
            n_bad++;
            $display("FAIL bp_frozen: got v=%b idx=%h en=%b want v=1 idx=%h en=1111",
                     bus.out_valid, bus.out_index, bus.out_byte_en, a[0][31:2]);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_index !== a[1][31:2]) begin n_bad++; $display("FAIL bp_second: got %h want %h", bus.out_index, a[1][31:2]); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_rise: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== a[2][31:2]) begin n_bad++; $display("FAIL bp_third: got v=%b idx=%h want v=1 idx=%h", bus.out_valid, bus.out_index, a[2][31:2]); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_model_empty: got %0d entries want 0", exp_q.size()); end
    endtask

    task automatic test_misalign();
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = base | 32'd3; bus.in_size = 2'd1;
        tick();
        bus.in_valid = 1'b0;
`ifdef WORD_INDEX_ALIGN_TRAP_EN
        n_cmp++; if ({bus.out_misalign, bus.out_byte_en} !== 5'b1_0000) begin n_bad++; $display("FAIL mis_half: got mis=%b en=%b want mis=1 en=0000", bus.out_misalign, bus.out_byte_en); end
        n_cmp++; if ({bus.err_sticky, bus.mis_count} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL mis_err_set: got %b/%0d want 1/1", bus.err_sticky, bus.mis_count); end
        bus.err_clr = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_cmp++; if ({bus.err_sticky, bus.mis_count} !== 9'd0) begin n_bad++; $display("FAIL mis_err_clr: got %b/%0d want 0/0", bus.err_sticky, bus.mis_count); end
        bus.in_valid = 1'b1; bus.in_size = 2'd2; bus.in_addr = base | 32'd1; tick();
        bus.err_clr = 1'b1; bus.in_addr = base | 32'd2; tick();
        bus.err_clr = 1'b0;
        n_cmp++; if ({bus.err_sticky, bus.mis_count} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL mis_set_wins: got %b/%0d want 1/1", bus.err_sticky, bus.mis_count); end
        for (int i = 0; i < 256; i++) begin
            bus.in_addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.mis_count !== 8'd255) begin n_bad++; $display("FAIL mis_saturate: got %0d want 255", bus.mis_count); end
        tick();
`else
        n_cmp++; if ({bus.out_misalign, bus.out_byte_en} !== 5'b0_1100) begin n_bad++; $display("FAIL align_half: got mis=%b en=%b want mis=0 en=1100", bus.out_misalign, bus.out_byte_en); end
        bus.out_ready = 1'b1; bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = base; bus.in_size = 2'd3;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if ({bus.out_misalign, bus.out_byte_en} !== 5'b0_1111) begin n_bad++; $display("FAIL align_size3: got mis=%b en=%b want mis=0 en=1111", bus.out_misalign, bus.out_byte_en); end
        n_cmp++; if ({bus.err_sticky, bus.mis_count} !== 9'd0) begin n_bad++; $display("FAIL align_err_tied: got %b/%0d want 0/0", bus.err_sticky, bus.mis_count); end
        tick();
`endif
    endtask

    task automatic test_random();
        ent_t h;
        for (int c = 0; c < 600; c++) begin
            n_cmp++;
            if (bus.in_ready !== (exp_q.size() < 2) || bus.out_valid !== (exp_q.size() != 0)) begin
                n_bad++;
                $display("FAIL rand_hs cyc %0d: got rdy=%b v=%b want occ=%0d", c, bus.in_ready, bus.out_valid, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                n_cmp++;
                if (bus.out_index !== h.idx || bus.out_byte_en !== h.ben || bus.out_misalign !== h.mis) begin
                    n_bad++;
                    $display("FAIL rand_head cyc %0d: got idx=%h en=%b mis=%b want idx=%h en=%b mis=%b",
                             c, bus.out_index, bus.out_byte_en, bus.out_misalign, h.idx, h.ben, h.mis);
                end
            end
            n_cmp++;
            if (bus.err_sticky !== m_sticky || bus.mis_count !== m_count) begin
                n_bad++;
                $display("FAIL rand_err cyc %0d: got %b/%0d want %b/%0d", c, bus.err_sticky, bus.mis_count, m_sticky, m_count);
            end
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_addr   = $urandom;
            bus.in_size   = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.err_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.err_clr = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_midop();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_size = 2'd2;
        bus.in_addr = $urandom & 32'hFFFF_FFFC; tick();
        bus.in_addr = $urandom & 32'hFFFF_FFFC; tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_full: got v=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready_in_rst: got %b want 0", bus.in_ready); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_flushed: got v=%b rdy=%b want 0/0", bus.out_valid, bus.in_ready); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_word_basic();
        test_byte_back_to_back();
        test_back_pressure();
        test_misalign();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
